mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the core's instruction-fetch master (m0) and data master (m1).
- Masters and the slave all use the req/gnt/rvalid protocol:
  - the request is accepted when req and gnt are both high in the same cycle;
  - responses return in order, at least 1 cycle after their grant.
- The block arbitrates requests round-robin, holds each request stable until the slave grants it, and routes responses back to the master that issued them.
- It sits between the core and the unified instruction/data RAM in the top level, and in the benches.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port between the
// instruction-fetch master (m0) and the data master (m1), with in-order response routing.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [ADDR_W-1:0]     m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [DATA_W/8-1:0]   m0_be_i,
    input  logic [DATA_W-1:0]     m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [DATA_W-1:0]     m0_rdata_o,

    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [ADDR_W-1:0]     m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [DATA_W/8-1:0]   m1_be_i,
    input  logic [DATA_W-1:0]     m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [DATA_W-1:0]     m1_rdata_o,
    output logic                  m1_err_o,

    output logic                  slv_req_o,
    input  logic                  slv_gnt_i,
    output logic [ADDR_W-1:0]     slv_addr_o,
    output logic                  slv_we_o,
    output logic [DATA_W/8-1:0]   slv_be_o,
    output logic [DATA_W-1:0]     slv_wdata_o,
    input  logic                  slv_rvalid_i,
    input  logic [DATA_W-1:0]     slv_rdata_i,
    input  logic                  slv_err_i,

    output logic                  busy_o,
    output logic                  proto_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTST - 1);

    logic [MAX_OUTST-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 last_id_q;
    logic                 lock_q;
    logic                 lock_id_q;
    logic                 proto_err_q;

    logic sel;
    logic full;
    logic has_outst;
    logic handshake;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A stalled request keeps ownership of the slave port until it is granted.
    always_comb begin
        sel = 1'b0;
        if (lock_q)
            sel = lock_id_q;
        else if (m0_req_i && m1_req_i)
            sel = ~last_id_q;
        else if (m1_req_i)
            sel = 1'b1;
    end

    assign full      = (count_q == MAX_CNT);
    assign has_outst = (count_q != '0);
    assign slv_req_o = (m0_req_i | m1_req_i) & ~full & ~rst_i;
    assign handshake = slv_req_o & slv_gnt_i;
    assign m0_gnt_o  = handshake & ~sel;
    assign m1_gnt_o  = handshake & sel;

    assign slv_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign slv_we_o    = sel ? m1_we_i    : m0_we_i;
    assign slv_be_o    = sel ? m1_be_i    : m0_be_i;
    assign slv_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign head        = fifo_q[rd_ptr_q];
    assign pop         = slv_rvalid_i & has_outst & ~rst_i;
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m1_err_o    = m1_rvalid_o & slv_err_i;
    assign m0_rdata_o  = slv_rdata_i;
    assign m1_rdata_o  = slv_rdata_i;

    assign busy_o      = has_outst;
    assign proto_err_o = proto_err_q;

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (handshake) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({handshake, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_id_q   <= 1'b1;
            lock_q      <= 1'b0;
            lock_id_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (handshake) begin
                last_id_q <= sel;
                lock_q    <= 1'b0;
            end else if (slv_req_o) begin
                lock_q    <= 1'b1;
                lock_id_q <= sel;
            end
            // A response with nothing outstanding is a slave protocol violation.
            if (slv_rvalid_i && !has_outst)
                proto_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (count_q <= MAX_CNT);
            assert (!(m0_gnt_o && m1_gnt_o));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grant ids are queued at stimulus
// time and popped when the bench returns a slave response.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m0_req_i, m1_req_i;
    logic              m0_gnt_o, m1_gnt_o;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
    logic              m0_we_i, m1_we_i;
    logic [3:0]        m0_be_i, m1_be_i;
    logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i;
    logic              m0_rvalid_o, m1_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic              m1_err_o;
    logic              slv_req_o, slv_gnt_i;
    logic [ADDR_W-1:0] slv_addr_o;
    logic              slv_we_o;
    logic [3:0]        slv_be_o;
    logic [DATA_W-1:0] slv_wdata_o;
    logic              slv_rvalid_i;
    logic [DATA_W-1:0] slv_rdata_i;
    logic              slv_err_i;
    logic              busy_o, proto_err_o;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_id_q[$];

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .m1_err_o(m1_err_o),
        .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_addr_o(slv_addr_o), .slv_we_o(slv_we_o),
        .slv_be_o(slv_be_o), .slv_wdata_o(slv_wdata_o), .slv_rvalid_i(slv_rvalid_i),
        .slv_rdata_i(slv_rdata_i), .slv_err_i(slv_err_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the grant outcome and records which master must receive the response.
    task automatic expect_gnt(input string tag, input bit g0, input bit g1);
        chk({tag, ".m0_gnt"}, 64'(m0_gnt_o), 64'(g0));
        chk({tag, ".m1_gnt"}, 64'(m1_gnt_o), 64'(g1));
        if (g0) exp_id_q.push_back(1'b0);
        if (g1) exp_id_q.push_back(1'b1);
    endtask

    task automatic expect_rsp(input string tag);
        bit id;
        if (exp_id_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed=empty_scoreboard expected=pending_id", tag);
        end else begin
            id = exp_id_q.pop_front();
            chk({tag, ".m0_rvalid"}, 64'(m0_rvalid_o), 64'(id == 1'b0));
            chk({tag, ".m1_rvalid"}, 64'(m1_rvalid_o), 64'(id == 1'b1));
            chk({tag, ".rdata"}, 64'(id ? m1_rdata_o : m0_rdata_o), 64'(slv_rdata_i));
        end
    endtask

    task automatic idle_inputs();
        m0_req_i = 0; m1_req_i = 0;
        m0_addr_i = '0; m1_addr_i = '0;
        m0_we_i = 0; m1_we_i = 0;
        m0_be_i = 4'hF; m1_be_i = 4'hF;
        m0_wdata_i = '0; m1_wdata_i = '0;
        slv_gnt_i = 0; slv_rvalid_i = 0; slv_rdata_i = '0; slv_err_i = 0;
    endtask

    initial begin
        idle_inputs();
        rst_i = 1;
        tick();
        // Outputs forced low while reset is held, even with live inputs.
        m0_req_i = 1; slv_gnt_i = 1; slv_rvalid_i = 1;
        settle();
        chk("rst.slv_req", 64'(slv_req_o), 64'(0));
        chk("rst.m0_gnt", 64'(m0_gnt_o), 64'(0));
        chk("rst.m0_rvalid", 64'(m0_rvalid_o), 64'(0));
        chk("rst.m1_rvalid", 64'(m1_rvalid_o), 64'(0));
        tick();
        idle_inputs();
        rst_i = 0;
        tick();
        chk("rst.busy", 64'(busy_o), 64'(0));
        chk("rst.proto_err", 64'(proto_err_o), 64'(0));

        // 1: m0 only, immediate grant, response one cycle later.
        m0_req_i = 1; m0_addr_i = 32'h0; slv_gnt_i = 1; settle();
        expect_gnt("t1.a", 1, 0);
        chk("t1.a.addr", 64'(slv_addr_o), 64'h0);
        tick();
        m0_addr_i = 32'h4; slv_rvalid_i = 1; slv_rdata_i = 32'h00300293; settle();
        expect_rsp("t1.b");
        expect_gnt("t1.b", 1, 0);
        chk("t1.b.addr", 64'(slv_addr_o), 64'h4);
        chk("t1.b.busy", 64'(busy_o), 64'(1));
        tick();
        m0_addr_i = 32'h8; settle();
        expect_rsp("t1.c");
        expect_gnt("t1.c", 1, 0);
        tick();
        m0_req_i = 0; settle();
        expect_rsp("t1.d");
        chk("t1.d.slv_req", 64'(slv_req_o), 64'(0));
        tick();
        slv_rvalid_i = 0; slv_gnt_i = 0; settle();
        chk("t1.e.busy", 64'(busy_o), 64'(0));
        chk("t1.e.m1_rvalid", 64'(m1_rvalid_o), 64'(0));

        // 2: both request every cycle after a fresh reset -> m0,m1,m0,m1.
        rst_i = 1; tick(); rst_i = 0;
        m0_req_i = 1; m0_addr_i = 32'h40;
        m1_req_i = 1; m1_addr_i = 32'hC; m1_we_i = 1; m1_be_i = 4'hF; m1_wdata_i = 32'hC;
        slv_gnt_i = 1; settle();
        expect_gnt("t2.1", 1, 0);
        chk("t2.1.addr", 64'(slv_addr_o), 64'h40);
        chk("t2.1.we", 64'(slv_we_o), 64'(0));
        tick();
        slv_rvalid_i = 1; slv_rdata_i = 32'h11; settle();
        expect_rsp("t2.2");
        expect_gnt("t2.2", 0, 1);
        chk("t2.2.addr", 64'(slv_addr_o), 64'hC);
        chk("t2.2.we", 64'(slv_we_o), 64'(1));
        chk("t2.2.be", 64'(slv_be_o), 64'hF);
        chk("t2.2.wdata", 64'(slv_wdata_o), 64'hC);
        tick();
        slv_rdata_i = 32'h22; settle();
        expect_rsp("t2.3");
        expect_gnt("t2.3", 1, 0);
        tick();
        slv_rdata_i = 32'h33; settle();
        expect_rsp("t2.4");
        expect_gnt("t2.4", 0, 1);
        tick();
        m0_req_i = 0; m1_req_i = 0; m1_we_i = 0; slv_rdata_i = 32'h44; settle();
        expect_rsp("t2.5");
        tick();
        slv_rvalid_i = 0; slv_gnt_i = 0; settle();
        chk("t2.6.busy", 64'(busy_o), 64'(0));

        // 3: stalled m0 keeps the port even though round-robin would favour m1.
        m0_req_i = 1; m0_addr_i = 32'h08; slv_gnt_i = 1; settle();
        expect_gnt("t3.pre", 1, 0);
        tick();
        m0_addr_i = 32'h10; slv_gnt_i = 0; slv_rvalid_i = 1; slv_rdata_i = 32'h55; settle();
        expect_rsp("t3.pre");
        chk("t3.s1.addr", 64'(slv_addr_o), 64'h10);
        tick();
        slv_rvalid_i = 0; m1_req_i = 1; m1_addr_i = 32'h14; settle();
        chk("t3.s2.addr", 64'(slv_addr_o), 64'h10);
        expect_gnt("t3.s2", 0, 0);
        tick();
        settle();
        chk("t3.s3.addr", 64'(slv_addr_o), 64'h10);
        chk("t3.s3.slv_req", 64'(slv_req_o), 64'(1));
        tick();
        slv_gnt_i = 1; settle();
        expect_gnt("t3.g", 1, 0);
        chk("t3.g.addr", 64'(slv_addr_o), 64'h10);
        tick();
        m0_addr_i = 32'h18; slv_rvalid_i = 1; slv_rdata_i = 32'h66; settle();
        expect_rsp("t3.n");
        expect_gnt("t3.n", 0, 1);
        chk("t3.n.addr", 64'(slv_addr_o), 64'h14);
        tick();
        m0_req_i = 0; m1_req_i = 0; slv_gnt_i = 0; slv_rdata_i = 32'h77; settle();
        expect_rsp("t3.r");
        tick();
        slv_rvalid_i = 0;

        // 4: two outstanding -> request withheld until a response, then one more cycle.
        m0_req_i = 1; m0_addr_i = 32'h100; slv_gnt_i = 1; settle();
        expect_gnt("t4.1", 1, 0);
        tick();
        settle();
        expect_gnt("t4.2", 1, 0);
        tick();
        settle();
        chk("t4.full.slv_req", 64'(slv_req_o), 64'(0));
        chk("t4.full.busy", 64'(busy_o), 64'(1));
        expect_gnt("t4.full", 0, 0);
        tick();
        slv_rvalid_i = 1; slv_rdata_i = 32'h88; settle();
        expect_rsp("t4.pop");
        chk("t4.pop.slv_req", 64'(slv_req_o), 64'(0));
        tick();
        slv_rvalid_i = 0; settle();
        chk("t4.re.slv_req", 64'(slv_req_o), 64'(1));
        expect_gnt("t4.re", 1, 0);
        tick();
        m0_req_i = 0; slv_rvalid_i = 1; slv_rdata_i = 32'h99; settle();
        expect_rsp("t4.d1");
        tick();
        slv_rdata_i = 32'hAA; settle();
        expect_rsp("t4.d2");
        tick();
        slv_rvalid_i = 0; slv_gnt_i = 0; settle();
        chk("t4.end.busy", 64'(busy_o), 64'(0));

        // 5: error routing only reaches m1.
        m1_req_i = 1; m1_addr_i = 32'h20; slv_gnt_i = 1; settle();
        expect_gnt("t5.1", 0, 1);
        tick();
        m1_req_i = 0; m0_req_i = 1; m0_addr_i = 32'h24;
        slv_rvalid_i = 1; slv_err_i = 1; slv_rdata_i = 32'hBAD; settle();
        expect_rsp("t5.2");
        chk("t5.2.m1_err", 64'(m1_err_o), 64'(1));
        expect_gnt("t5.2", 1, 0);
        tick();
        m0_req_i = 0; settle();
        expect_rsp("t5.3");
        chk("t5.3.m1_err", 64'(m1_err_o), 64'(0));
        tick();
        slv_rvalid_i = 0; slv_err_i = 0; slv_gnt_i = 0;

        // 6: stray rvalid is flagged and sticks; reset clears state and priority.
        slv_rvalid_i = 1; settle();
        chk("t6.stray.m0_rvalid", 64'(m0_rvalid_o), 64'(0));
        chk("t6.stray.m1_rvalid", 64'(m1_rvalid_o), 64'(0));
        tick();
        slv_rvalid_i = 0; settle();
        chk("t6.proto1", 64'(proto_err_o), 64'(1));
        tick();
        settle();
        chk("t6.proto2", 64'(proto_err_o), 64'(1));
        m0_req_i = 1; m0_addr_i = 32'h30; slv_gnt_i = 1; settle();
        expect_gnt("t6.g", 1, 0);
        tick();
        m0_req_i = 0; slv_gnt_i = 0; rst_i = 1;
        tick();
        rst_i = 0;
        void'(exp_id_q.pop_back());
        settle();
        chk("t6.rst.busy", 64'(busy_o), 64'(0));
        chk("t6.rst.proto", 64'(proto_err_o), 64'(0));
        m0_req_i = 1; m1_req_i = 1; m0_addr_i = 32'h34; m1_addr_i = 32'h38; slv_gnt_i = 1; settle();
        expect_gnt("t6.tie", 1, 0);
        tick();
        m0_req_i = 0; m1_req_i = 0; slv_gnt_i = 0; slv_rvalid_i = 1; slv_rdata_i = 32'hCC; settle();
        expect_rsp("t6.rsp");
        tick();
        slv_rvalid_i = 0; settle();
        chk("t6.end.busy", 64'(busy_o), 64'(0));
        chk("t6.end.proto", 64'(proto_err_o), 64'(0));
        chk("sb.empty", 64'(exp_id_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
